// File: rtl/tmds_serializer_sdr.sv
`default_nettype none
// ============================================================================
// tmds_serializer_sdr : 10:1 SDR TMDS lane serializer, LSB first; pixel_clk is
//                       sampled as a word strobe. Option macro: TMDS_SER_LOCK_EN
// Revision: 1.0
// ============================================================================
module tmds_serializer_sdr #(
   parameter int WORD_W   = 10,
   parameter int SYNC_LEN = 2
) (
   input  logic              serial_clk,
   input  logic              rst,
   input  logic              pixel_clk,
   input  logic [WORD_W-1:0] din,
   output logic              dout,
   output logic              dout_p,
   output logic              dout_n,
   output logic              locked
);

   localparam int               CNT_W    = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   logic [SYNC_LEN-1:0] sync_q;
   logic                hist_q;
   logic                rise;
   logic                load;
   state_t              state;
   logic [WORD_W-1:0]   shreg;
   logic [CNT_W-1:0]    cnt;

   always_ff @(posedge serial_clk) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_LEN-2:0], pixel_clk};
         hist_q <= sync_q[SYNC_LEN-1];
      end
   end

   assign rise = sync_q[SYNC_LEN-1] & ~hist_q;

   // A rise landing on the flywheel point collapses into the same single load.
   assign load = rise | (cnt == CNT_LAST);

   always_ff @(posedge serial_clk) begin
      if (rst) begin
         state <= ST_IDLE;
         shreg <= '0;
         cnt   <= '0;
         dout  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rise) begin
                  state <= ST_RUN;
                  dout  <= din[0];
                  shreg <= din >> 1;
                  cnt   <= '0;
               end
            end
            ST_RUN: begin
               if (load) begin
                  dout  <= din[0];
                  shreg <= din >> 1;
                  cnt   <= '0;
               end else begin
                  dout  <= shreg[0];
                  shreg <= shreg >> 1;
                  cnt   <= cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign dout_p = dout;
   assign dout_n = ~dout;

`ifdef TMDS_SER_LOCK_EN
   localparam int               GAP_W    = $clog2(WORD_W + 2);
   localparam logic [GAP_W-1:0] GAP_WORD = GAP_W'(WORD_W);
   localparam logic [GAP_W-1:0] GAP_MAX  = '1;

   // gap == 0 means no rise seen yet; it saturates so long gaps never alias WORD_W.
   logic [GAP_W-1:0] gap;
   logic             lock_q;

   always_ff @(posedge serial_clk) begin
      if (rst) begin
         gap    <= '0;
         lock_q <= 1'b0;
      end else if (rise) begin
         lock_q <= (gap == GAP_WORD);
         gap    <= GAP_W'(1);
      end else if ((gap != '0) && (gap != GAP_MAX)) begin
         gap <= gap + GAP_W'(1);
      end
   end

   assign locked = lock_q;
`else
   assign locked = ~rst;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmds_serializer_sdr.sv
`default_nettype none
// tb_tmds_serializer_sdr : directed scenarios plus randomized traffic, checked
// against a word/bit-index reference model built from the pixel_clk sample history.
module tb_tmds_serializer_sdr;

   localparam int WORD_W   = 10;
   localparam int SYNC_LEN = 2;

   logic              clk       = 1'b0;
   logic              rst       = 1'b0;
   logic              pixel_clk = 1'b0;
   logic [WORD_W-1:0] din       = '0;
   logic              dout;
   logic              dout_p;
   logic              dout_n;
   logic              locked;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   tmds_serializer_sdr #(
      .WORD_W   (WORD_W),
      .SYNC_LEN (SYNC_LEN)
   ) dut (
      .serial_clk (clk),
      .rst        (rst),
      .pixel_clk  (pixel_clk),
      .din        (din),
      .dout       (dout),
      .dout_p     (dout_p),
      .dout_n     (dout_n),
      .locked     (locked)
   );

   // Reference model: pixel_clk samples since reset, the word being sent and
   // the index of the bit currently on the line.
   bit                hist[$];
   logic [WORD_W-1:0] m_word      = '0;
   int                m_idx       = 0;
   bit                m_run       = 1'b0;
   bit                m_lock      = 1'b0;
   int                m_edge      = 0;
   int                m_last_rise = -1;

   int                ph       = 0;
   bit                alt      = 1'b0;
   logic [WORD_W-1:0] din_cur  = '0;

   function automatic bit past(int back);
      int i;
      i = hist.size() - 1 - back;
      return (i >= 0) ? hist[i] : 1'b0;
   endfunction

   task automatic check(string tag, logic obs, logic exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit p, input logic [WORD_W-1:0] d);
      bit rise_m;
      bit load_m;
      bit exp_dout;
      bit exp_lock;
      rst       = r;
      pixel_clk = p;
      din       = d;
      @(posedge clk);
      m_edge++;
      if (r) begin
         hist.delete();
         m_run       = 1'b0;
         m_idx       = 0;
         m_word      = '0;
         m_lock      = 1'b0;
         m_last_rise = -1;
      end else begin
         // A high sample SYNC_LEN edges ago preceded by a low one is a word boundary now.
         rise_m = past(SYNC_LEN - 1) && !past(SYNC_LEN);
         load_m = rise_m || (m_run && m_idx == WORD_W - 1);
         if (load_m) begin
            m_word = d;
            m_idx  = 0;
            m_run  = 1'b1;
         end else if (m_run) begin
            m_idx++;
         end
         if (rise_m) begin
            m_lock      = (m_last_rise >= 0) && (m_edge - m_last_rise == WORD_W);
            m_last_rise = m_edge;
         end
         hist.push_back(p);
         if (hist.size() > 8) void'(hist.pop_front());
      end
      exp_dout = m_run ? m_word[m_idx] : 1'b0;
`ifdef TMDS_SER_LOCK_EN
      exp_lock = m_lock;
`else
      exp_lock = !r;
`endif
      #1;
      check("dout",   dout,   exp_dout);
      check("dout_p", dout_p, exp_dout);
      check("dout_n", dout_n, !exp_dout);
      check("locked", locked, exp_lock);
   endtask

   // period 0 holds pixel_clk high; mode 0 fixed din, 1 alternating 3FF/000, 2 random per word.
   task automatic run(int cycles, int period, int mode, logic [WORD_W-1:0] fixed, int rst_pct);
      for (int i = 0; i < cycles; i++) begin
         bit p;
         bit r;
         if (period == 0) begin
            p = 1'b1;
         end else begin
            if (ph >= period) ph = 0;
            p = (ph < (period + 1) / 2);
            if (ph == 0) begin
               alt = !alt;
               case (mode)
                  1:       din_cur = alt ? 10'h3FF : 10'h000;
                  2:       din_cur = WORD_W'($urandom);
                  default: din_cur = fixed;
               endcase
            end
            ph++;
         end
         if (mode == 0) din_cur = fixed;
         r = ($urandom_range(99) < rst_pct);
         step(r, p, din_cur);
      end
   endtask

   initial begin
      // Reset held with pixel_clk wiggling: outputs must stay in reset state.
      for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom), WORD_W'($urandom));

      ph = 0;
      run(60, 10, 0, 10'b1010101011, 0);
      run(40, 10, 1, '0, 0);
      run(40, 5, 0, 10'b1010101011, 0);
      ph = 0;
      run(40, 10, 0, 10'b1010101011, 0);
      run(40, 0, 0, 10'h155, 0);

      // Reset in the middle of a word, then idle with pixel_clk low before restarting.
      ph = 0;
      run(14, 10, 0, 10'h2CB, 0);
      step(1'b1, 1'b0, 10'h2CB);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 10'h2CB);
      ph = 0;
      run(40, 10, 2, '0, 0);

      // Randomized traffic: assorted spacings, stalled strobe, sporadic resets.
      for (int b = 0; b < 30; b++) begin
         int per;
         per = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(14, 3));
         if ($urandom_range(3) == 0) per = 10;
         run(int'($urandom_range(80, 20)), per, 2, '0, ($urandom_range(3) == 0) ? 2 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
